// File: rtl/dmem_arbiter_if.sv
// Purpose : bundle of the requester handshake and RAM strobe signals around
//           dmem_arbiter.
// Modports:
//   slave  - arbiter view: requests/commands and RAM read_data in,
//            grants/read results/RAM strobes out.
//   master - environment view (requesters + RAM), the mirror image.
// Signals : req0/1, we0/1, addr0/1, wdata0/1, gnt0/1, rvalid0/1, rdata, busy,
//           MemRead, MemWrite, address, write_data, read_data.
interface dmem_arbiter_if #(
   parameter int AW = 10,
   parameter int DW = 32
);
   logic          req0, req1;
   logic          we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1;
   logic          rvalid0, rvalid1;
   logic [DW-1:0] rdata;
   logic          busy;
   logic          MemRead, MemWrite;
   logic [AW-1:0] address;
   logic [DW-1:0] write_data;
   logic [DW-1:0] read_data;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, read_data,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
             MemRead, MemWrite, address, write_data
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, read_data,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
             MemRead, MemWrite, address, write_data
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose : shares the single-port data RAM between the CPU load/store unit
//           (port 0) and the DMA/program loader (port 1). Each winning command
//           is registered, issued to the RAM for one cycle, and reads return
//           data on the shared rdata bus with a per-port rvalid pulse.
// Ports   : CLK  - clock, rising edge
//           RSTn - asynchronous active-low reset
//           bus  - dmem_arbiter_if.slave (requests, grants, read results,
//                  RAM strobes/address/data)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | sampling requests; winner's command captured on the edge
// ISSUE  | command on the RAM strobes, gnt pulse to the winner
// RDWAIT | RAM read data valid; captured into rdata on the edge
module dmem_arbiter #(
   parameter int AW         = 10,
   parameter int DW         = 32,
   parameter int CPU_PRIO   = 1,
   parameter int STARVE_LIM = 4
) (
   input logic            CLK,
   input logic            RSTn,
   dmem_arbiter_if.slave  bus
);
   localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_RDWAIT = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          win_q, win_d;
   logic          we_q;
   logic          prio_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;
   logic          rvalid0_q, rvalid1_q;
   logic [SW-1:0] starve_q, starve_d;
   logic          any_req;
   logic          arb_now;

   assign any_req = bus.req0 | bus.req1;
   assign arb_now = (state_q == S_IDLE) & any_req;

   // win_d = 1 selects port 1. prio_q holds the port favoured on a tie in
   // round-robin mode (the one not granted last).
   always_comb begin
      win_d = 1'b0;
      if (CPU_PRIO != 0) begin
         win_d = bus.req1 & (~bus.req0 | (starve_q == STARVE_MAX));
      end else begin
         win_d = bus.req1 & (~bus.req0 | prio_q);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (any_req) state_d = S_ISSUE;
         S_ISSUE:  state_d = we_q ? S_IDLE : S_RDWAIT;
         S_RDWAIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Counts port-0 wins that port 1 sat through; saturates so port 1 is
   // forced on the next contested arbitration.
   always_comb begin
      starve_d = starve_q;
      if (!bus.req1) begin
         starve_d = '0;
      end else if (arb_now) begin
         if (win_d) begin
            starve_d = '0;
         end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q   <= S_IDLE;
         win_q     <= 1'b0;
         we_q      <= 1'b0;
         prio_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         starve_q  <= '0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         if (arb_now) begin
            win_q   <= win_d;
            we_q    <= win_d ? bus.we1    : bus.we0;
            addr_q  <= win_d ? bus.addr1  : bus.addr0;
            wdata_q <= win_d ? bus.wdata1 : bus.wdata0;
            prio_q  <= ~win_d;
         end
         if (state_q == S_RDWAIT) begin
            rdata_q   <= bus.read_data;
            rvalid0_q <= ~win_q;
            rvalid1_q <= win_q;
         end
      end
   end

   // Address/data hold the last command outside ISSUE; only the strobes
   // qualify them, and we_q makes the two strobes mutually exclusive.
   assign bus.gnt0       = (state_q == S_ISSUE) & ~win_q;
   assign bus.gnt1       = (state_q == S_ISSUE) &  win_q;
   assign bus.MemRead    = (state_q == S_ISSUE) & ~we_q;
   assign bus.MemWrite   = (state_q == S_ISSUE) &  we_q;
   assign bus.address    = addr_q;
   assign bus.write_data = wdata_q;
   assign bus.rdata      = rdata_q;
   assign bus.rvalid0    = rvalid0_q;
   assign bus.rvalid1    = rvalid1_q;
   assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : self-checking bench for dmem_arbiter. Two instances: u_a in
//           round-robin mode, u_b with CPU priority and STARVE_LIM=4. Each has
//           a synchronous RAM model; a shadow memory predicts read data.
module tb_dmem_arbiter;
   localparam int LIM = 4;

   logic CLK = 1'b0;
   logic RSTn;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 CLK = ~CLK;

   dmem_arbiter_if #(.AW(10), .DW(32)) ifa ();
   dmem_arbiter_if #(.AW(10), .DW(32)) ifb ();

   dmem_arbiter #(.AW(10), .DW(32), .CPU_PRIO(0), .STARVE_LIM(LIM)) u_a (
      .CLK(CLK), .RSTn(RSTn), .bus(ifa));
   dmem_arbiter #(.AW(10), .DW(32), .CPU_PRIO(1), .STARVE_LIM(LIM)) u_b (
      .CLK(CLK), .RSTn(RSTn), .bus(ifb));

   logic [31:0] mem_a [1024];
   logic [31:0] mem_b [1024];

   always @(posedge CLK) begin
      if (ifa.MemWrite) mem_a[ifa.address] <= ifa.write_data;
      if (ifa.MemRead)  ifa.read_data <= mem_a[ifa.address];
      if (ifb.MemWrite) mem_b[ifb.address] <= ifb.write_data;
      if (ifb.MemRead)  ifb.read_data <= mem_b[ifb.address];
   end

   logic [31:0] sh    [2][1024];
   bit          known [2][1024];

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(int d, int p, logic v, logic we, logic [9:0] a, logic [31:0] wd);
      if (d == 0) begin
         if (p == 0) begin ifa.req0 = v; ifa.we0 = we; ifa.addr0 = a; ifa.wdata0 = wd; end
         else        begin ifa.req1 = v; ifa.we1 = we; ifa.addr1 = a; ifa.wdata1 = wd; end
      end else begin
         if (p == 0) begin ifb.req0 = v; ifb.we0 = we; ifb.addr0 = a; ifb.wdata0 = wd; end
         else        begin ifb.req1 = v; ifb.we1 = we; ifb.addr1 = a; ifb.wdata1 = wd; end
      end
   endtask

   function automatic logic g(int d, int p);
      if (d == 0) return (p == 0) ? ifa.gnt0 : ifa.gnt1;
      return (p == 0) ? ifb.gnt0 : ifb.gnt1;
   endfunction
   function automatic logic rv(int d, int p);
      if (d == 0) return (p == 0) ? ifa.rvalid0 : ifa.rvalid1;
      return (p == 0) ? ifb.rvalid0 : ifb.rvalid1;
   endfunction
   function automatic logic mr(int d);  return (d == 0) ? ifa.MemRead  : ifb.MemRead;  endfunction
   function automatic logic mw(int d);  return (d == 0) ? ifa.MemWrite : ifb.MemWrite; endfunction
   function automatic logic bz(int d);  return (d == 0) ? ifa.busy     : ifb.busy;     endfunction
   function automatic logic [9:0]  adr(int d); return (d == 0) ? ifa.address    : ifb.address;    endfunction
   function automatic logic [31:0] wdt(int d); return (d == 0) ? ifa.write_data : ifb.write_data; endfunction
   function automatic logic [31:0] rd(int d);  return (d == 0) ? ifa.rdata      : ifb.rdata;      endfunction

   // One single-port access, started at a negedge with the arbiter idle.
   // Returns at a negedge with the arbiter idle again.
   task automatic txn(int d, int p, logic we, logic [9:0] a, logic [31:0] wd);
      logic [31:0] expd;
      bit          kn;
      drive(d, p, 1'b1, we, a, wd);
      @(negedge CLK);
      chk("gnt",        32'(g(d, p)),     32'd1);
      chk("gnt_other",  32'(g(d, 1 - p)), 32'd0);
      chk("MemRead",    32'(mr(d)),       32'(!we));
      chk("MemWrite",   32'(mw(d)),       32'(we));
      chk("address",    32'(adr(d)),      32'(a));
      if (we) chk("write_data", wdt(d), wd);
      drive(d, p, 1'b0, we, a, wd);
      if (we) begin
         sh[d][a]    = wd;
         known[d][a] = 1'b1;
         @(negedge CLK);
         chk("busy_after_write", 32'(bz(d)), 32'd0);
      end else begin
         kn   = known[d][a];
         expd = sh[d][a];
         @(negedge CLK);
         chk("rdwait_busy",    32'(bz(d)),    32'd1);
         chk("rdwait_MemRead", 32'(mr(d)),    32'd0);
         chk("rdwait_rvalid",  32'(rv(d, p)), 32'd0);
         @(negedge CLK);
         chk("rvalid",       32'(rv(d, p)),     32'd1);
         chk("rvalid_other", 32'(rv(d, 1 - p)), 32'd0);
         if (kn) chk("rdata", rd(d), expd);
      end
   endtask

   // Both ports hold read requests; the expected winner of the k-th grant is
   // derived from the arbitration rule directly: alternation in round-robin
   // mode, and one port-1 grant after every LIM port-0 grants with priority.
   task automatic both_held(int d, int ngr, logic [9:0] a0, logic [9:0] a1);
      int ew;
      drive(d, 0, 1'b1, 1'b0, a0, 32'd0);
      drive(d, 1, 1'b1, 1'b0, a1, 32'd0);
      for (int k = 0; k < ngr; k++) begin
         ew = (d == 0) ? (k % 2) : ((k % (LIM + 1)) == LIM ? 1 : 0);
         @(negedge CLK);
         chk($sformatf("seq_gnt%0d_k%0d", ew, k), 32'(g(d, ew)),     32'd1);
         chk($sformatf("seq_nogn_k%0d", k),       32'(g(d, 1 - ew)), 32'd0);
         @(negedge CLK);
         @(negedge CLK);
         chk($sformatf("seq_rvalid%0d_k%0d", ew, k), 32'(rv(d, ew)), 32'd1);
         chk($sformatf("seq_rdata_k%0d", k), rd(d), sh[d][(ew == 1) ? a1 : a0]);
      end
      drive(d, 0, 1'b0, 1'b0, a0, 32'd0);
      drive(d, 1, 1'b0, 1'b0, a1, 32'd0);
   endtask

   initial begin
      logic [9:0]  a0, a1, a5, ra;
      logic [31:0] rdat;
      int          p;

      RSTn = 1'b0;
      for (int d = 0; d < 2; d++)
         for (int q = 0; q < 2; q++) drive(d, q, 1'b0, 1'b0, 10'd0, 32'd0);
      ifa.read_data = '0;
      ifb.read_data = '0;

      // 1: reset with req0 held on the priority instance
      a0 = 10'($urandom_range(0, 1023));
      drive(1, 0, 1'b1, 1'b0, a0, 32'd0);
      repeat (3) @(negedge CLK);
      chk("rst_gnt0",     32'(ifb.gnt0),     32'd0);
      chk("rst_gnt1",     32'(ifb.gnt1),     32'd0);
      chk("rst_rvalid0",  32'(ifb.rvalid0),  32'd0);
      chk("rst_rvalid1",  32'(ifb.rvalid1),  32'd0);
      chk("rst_MemRead",  32'(ifb.MemRead),  32'd0);
      chk("rst_MemWrite", 32'(ifb.MemWrite), 32'd0);
      chk("rst_busy",     32'(ifb.busy),     32'd0);
      chk("rst_address",  32'(ifb.address),  32'd0);
      chk("rst_wdata",    ifb.write_data,    32'd0);
      chk("rst_rdata",    ifb.rdata,         32'd0);
      chk("rst_a_busy",   32'(ifa.busy),     32'd0);
      RSTn = 1'b1;
      @(negedge CLK);
      chk("post_rst_gnt0",    32'(ifb.gnt0),    32'd1);
      chk("post_rst_MemRead", 32'(ifb.MemRead), 32'd1);
      chk("post_rst_address", 32'(ifb.address), 32'(a0));
      drive(1, 0, 1'b0, 1'b0, a0, 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      chk("post_rst_rvalid0", 32'(ifb.rvalid0), 32'd1);

      // 2: port-0 write then read back
      txn(1, 0, 1'b1, 10'h005, 32'hDEADBEEF);
      txn(1, 0, 1'b0, 10'h005, 32'd0);
      chk("t2_rdata", ifb.rdata, 32'hDEADBEEF);

      // 3: round-robin; prefill ends on a port-1 grant so port 0 goes next
      a0 = 10'($urandom_range(0, 511));
      a1 = 10'($urandom_range(512, 1023));
      txn(0, 0, 1'b1, a0, $urandom);
      txn(0, 1, 1'b1, a1, $urandom);
      both_held(0, 8, a0, a1);

      // 4: CPU priority with starvation guard
      txn(1, 0, 1'b1, a0, $urandom);
      txn(1, 1, 1'b1, a1, $urandom);
      @(negedge CLK);
      both_held(1, 10, a0, a1);

      // 5: reset during the RDWAIT of a port-1 read
      a5 = 10'h2A0;
      txn(1, 1, 1'b1, a5, $urandom);
      drive(1, 1, 1'b1, 1'b0, a5, 32'd0);
      @(negedge CLK);
      chk("t5_gnt1", 32'(ifb.gnt1), 32'd1);
      drive(1, 1, 1'b0, 1'b0, a5, 32'd0);
      @(negedge CLK);
      chk("t5_rdwait_busy", 32'(ifb.busy), 32'd1);
      RSTn = 1'b0;
      #1;
      chk("t5_async_busy", 32'(ifb.busy), 32'd0);
      @(negedge CLK);
      chk("t5_rvalid1_rst", 32'(ifb.rvalid1), 32'd0);
      RSTn = 1'b1;
      @(negedge CLK);
      chk("t5_rvalid1_after", 32'(ifb.rvalid1), 32'd0);
      chk("t5_idle",          32'(ifb.busy),    32'd0);
      chk("t5_no_gnt",        32'(ifb.gnt1),    32'd0);
      txn(1, 1, 1'b0, a5, 32'd0);

      // 6: req1 dropped during ISSUE; the write still completes
      drive(1, 1, 1'b1, 1'b1, 10'h3FF, 32'h1234);
      @(posedge CLK);
      #1;
      chk("t6_issue_busy", 32'(ifb.busy), 32'd1);
      drive(1, 1, 1'b0, 1'b1, 10'h3FF, 32'h1234);
      @(negedge CLK);
      chk("t6_gnt1",     32'(ifb.gnt1),     32'd1);
      chk("t6_MemWrite", 32'(ifb.MemWrite), 32'd1);
      chk("t6_address",  32'(ifb.address),  32'h3FF);
      chk("t6_wdata",    ifb.write_data,    32'h1234);
      @(negedge CLK);
      chk("t6_ram", mem_b[10'h3FF], 32'h1234);
      sh[1][10'h3FF]    = 32'h1234;
      known[1][10'h3FF] = 1'b1;
      txn(1, 0, 1'b0, 10'h3FF, 32'd0);

      // random single-port traffic on both instances
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 30; i++) begin
            p    = int'($urandom_range(0, 1));
            ra   = 10'h100 + 10'($urandom_range(0, 7));
            rdat = $urandom;
            if (!known[d][ra] || $urandom_range(0, 1) == 0) txn(d, p, 1'b1, ra, rdat);
            else                                           txn(d, p, 1'b0, ra, 32'd0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
